// File: rtl/spi_reg_ctrl.sv
// rtl/spi_reg_ctrl.sv - SPI-target (mode 0) write port for the five PWM config registers
// Optional macro SPI_READBACK_EN builds the read path on cipo.
module spi_reg_ctrl #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [6:0] MAX_ADDR    = 7'h04
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic       cipo,
    output logic       cipo_oe,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       frame_err
);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    localparam int NUM_REGS = 5;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] copi_sync_q, copi_sync_d;
    logic [SYNC_STAGES-1:0] ncs_sync_q, ncs_sync_d;
    logic                   sclk_dly_q, sclk_dly_d;
    logic                   ncs_dly_q, ncs_dly_d;
    logic [4:0]             cnt_q, cnt_d;
    logic [15:0]            shreg_q, shreg_d;
    logic [7:0]             regs_q [NUM_REGS];
    logic [7:0]             regs_d [NUM_REGS];

    logic sclk_s, copi_s, ncs_s;
    logic sclk_rise, ncs_rise, ncs_fall;
    logic commit_write;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign copi_s    = copi_sync_q[SYNC_STAGES-1];
    assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_dly_q;
    assign ncs_rise  = ncs_s & ~ncs_dly_q;
    assign ncs_fall  = ~ncs_s & ncs_dly_q;

    assign commit_write = (state_q == COMMIT) && (cnt_q == 5'd16) &&
                          shreg_q[15] && (shreg_q[14:8] <= MAX_ADDR);

`ifdef SPI_READBACK_EN
    logic [7:0] tx_q, tx_d;
    logic       sclk_fall;
    logic [7:0] rd_data;
    logic [15:0] rx_next;

    assign sclk_fall = ~sclk_s & sclk_dly_q;
    assign rx_next   = {shreg_q[14:0], copi_s};

    always_comb begin
        rd_data = 8'h00;
        if (rx_next[6:0] <= MAX_ADDR) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (rx_next[6:0] == 7'(i)) rd_data = regs_q[i];
            end
        end
    end

    // The byte is loaded on the 8th rise and held across the following fall,
    // so bit 7 is on cipo before the 9th rise.
    always_comb begin
        tx_d = tx_q;
        if (ncs_fall && (state_q != SHIFT)) begin
            tx_d = 8'h00;
        end else if (state_q == SHIFT && !ncs_s) begin
            if (sclk_rise && cnt_q == 5'd7 && !rx_next[7]) begin
                tx_d = rd_data;
            end else if (sclk_fall && cnt_q >= 5'd9) begin
                tx_d = {tx_q[6:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tx_q <= 8'h00;
        else        tx_q <= tx_d;
    end

    assign cipo    = tx_q[7];
    assign cipo_oe = ~ncs_s;
`else
    assign cipo    = 1'b0;
    assign cipo_oe = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sclk_sync_q <= '0;
            copi_sync_q <= '0;
            ncs_sync_q  <= '1;
            sclk_dly_q  <= 1'b0;
            ncs_dly_q   <= 1'b1;
            cnt_q       <= 5'd0;
            shreg_q     <= 16'h0000;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 8'h00;
        end else begin
            state_q     <= state_d;
            sclk_sync_q <= sclk_sync_d;
            copi_sync_q <= copi_sync_d;
            ncs_sync_q  <= ncs_sync_d;
            sclk_dly_q  <= sclk_dly_d;
            ncs_dly_q   <= ncs_dly_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
        end
    end

    // A chip-select blip of one synced cycle falls during COMMIT, so COMMIT
    // can start the next frame directly.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ncs_fall) state_d = SHIFT;
            SHIFT:   if (ncs_rise) state_d = COMMIT;
            COMMIT:  state_d = ncs_fall ? SHIFT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        copi_sync_d = {copi_sync_q[SYNC_STAGES-2:0], copi};
        ncs_sync_d  = {ncs_sync_q[SYNC_STAGES-2:0], ncs};
        sclk_dly_d  = sclk_s;
        ncs_dly_d   = ncs_s;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        for (int i = 0; i < NUM_REGS; i++) regs_d[i] = regs_q[i];

        case (state_q)
            IDLE: begin
                if (ncs_fall) begin
                    cnt_d   = 5'd0;
                    shreg_d = 16'h0000;
                end
            end
            SHIFT: begin
                // ncs_rise implies ncs_s high, so a coincident sclk rise is dropped
                if (sclk_rise && !ncs_s) begin
                    shreg_d = {shreg_q[14:0], copi_s};
                    if (cnt_q != 5'd17) cnt_d = cnt_q + 5'd1;
                end
            end
            COMMIT: begin
                if (commit_write) begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (shreg_q[14:8] == 7'(i)) regs_d[i] = shreg_q[7:0];
                    end
                end
                if (ncs_fall) begin
                    cnt_d   = 5'd0;
                    shreg_d = 16'h0000;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        frame_err = (state_q == COMMIT) && (cnt_q != 5'd16);
    end

    assign en_reg_out_7_0  = regs_q[0];
    assign en_reg_out_15_8 = regs_q[1];
    assign en_reg_pwm_7_0  = regs_q[2];
    assign en_reg_pwm_15_8 = regs_q[3];
    assign pwm_duty_cycle  = regs_q[4];

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb/tb_spi_reg_ctrl.sv - directed self-checking bench for spi_reg_ctrl
module tb_spi_reg_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sclk, copi, ncs;
    logic       cipo, cipo_oe;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
    logic       frame_err;

    int checks = 0;
    int errors = 0;
    int err_pulses = 0;
    logic [31:0] cipo_cap;
    logic        oe_mid;

    spi_reg_ctrl dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs),
        .cipo(cipo), .cipo_oe(cipo_oe),
        .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
        .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
        .pwm_duty_cycle(pwm_duty_cycle), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n === 1'b1 && frame_err === 1'b1) err_pulses++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_regs(input string tag, input logic [7:0] r0, input logic [7:0] r1,
                            input logic [7:0] r2, input logic [7:0] r3, input logic [7:0] r4);
        chk({tag, ".out_7_0"},  32'(en_reg_out_7_0),  32'(r0));
        chk({tag, ".out_15_8"}, 32'(en_reg_out_15_8), 32'(r1));
        chk({tag, ".pwm_7_0"},  32'(en_reg_pwm_7_0),  32'(r2));
        chk({tag, ".pwm_15_8"}, 32'(en_reg_pwm_15_8), 32'(r3));
        chk({tag, ".duty"},     32'(pwm_duty_cycle),  32'(r4));
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drops ncs, clocks out nbits of val MSB first, leaves ncs low.
    task automatic frame_body(input logic [31:0] val, input int nbits);
        ncs = 1'b0;
        cipo_cap = 32'h0;
        clks(4);
        oe_mid = cipo_oe;
        for (int i = nbits - 1; i >= 0; i--) begin
            copi = val[i];
            clks(4);
            if ((nbits - 1 - i) >= 8) cipo_cap = {cipo_cap[30:0], cipo};
            sclk = 1'b1;
            clks(4);
            sclk = 1'b0;
        end
        clks(4);
    endtask

    task automatic send_frame(input logic [31:0] val, input int nbits);
        frame_body(val, nbits);
        ncs = 1'b1;
        clks(8);
    endtask

    initial begin
        int base;
        rst_n = 1'b0; sclk = 1'b0; copi = 1'b0; ncs = 1'b1;
        clks(3);
        chk_regs("reset", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        chk("reset.cipo", 32'(cipo), 32'h0);
        chk("reset.cipo_oe", 32'(cipo_oe), 32'h0);
        chk("reset.frame_err", 32'(frame_err), 32'h0);
        rst_n = 1'b1;
        clks(4);

        // 1: duty write and commit latency (SYNC_STAGES+2 clocks after ncs rises)
        frame_body(32'h8455, 16);
        ncs = 1'b1;
        clks(3);
        chk("t1.before_commit", 32'(pwm_duty_cycle), 32'h00);
        clks(1);
        chk("t1.after_commit", 32'(pwm_duty_cycle), 32'h55);
        clks(8);
        chk_regs("t1", 8'h00, 8'h00, 8'h00, 8'h00, 8'h55);
        chk("t1.err_pulses", 32'(err_pulses), 32'd0);

        // 2: back-to-back writes, register stable mid-frame
        send_frame(32'h80FF, 16);
        frame_body(32'h81A5, 16);
        chk("t2.midframe_out_15_8", 32'(en_reg_out_15_8), 32'h00);
        ncs = 1'b1;
        clks(8);
        chk_regs("t2", 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h55);
        chk("t2.err_pulses", 32'(err_pulses), 32'd0);
`ifdef SPI_READBACK_EN
        chk("t2.oe_mid", 32'(oe_mid), 32'h1);
`else
        chk("t2.oe_mid", 32'(oe_mid), 32'h0);
`endif

        // 3: out-of-range address and read frame are ignored silently
        send_frame(32'h8A3C, 16);
        send_frame(32'h0233, 16);
        chk_regs("t3", 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h55);
        chk("t3.err_pulses", 32'(err_pulses), 32'd0);

        // 4: short and long frames to addr 0x02
        base = err_pulses;
        send_frame(32'h8299 >> 1, 15);
        chk("t4.short_err", 32'(err_pulses - base), 32'd1);
        send_frame({15'h0, 16'h8299, 1'b1}, 17);
        chk("t4.long_err", 32'(err_pulses - base), 32'd2);
        chk("t4.pwm_7_0", 32'(en_reg_pwm_7_0), 32'h00);

        // 5: reset after 10 bits, then a full frame
        ncs = 1'b0;
        clks(4);
        for (int i = 15; i >= 6; i--) begin
            copi = 1'(32'h8377 >> i);
            clks(4);
            sclk = 1'b1;
            clks(4);
            sclk = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        chk_regs("t5.async_reset", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        ncs = 1'b1; sclk = 1'b0; copi = 1'b0;
        clks(3);
        rst_n = 1'b1;
        base = err_pulses;
        clks(8);
        chk_regs("t5.after_release", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        send_frame(32'h8377, 16);
        chk_regs("t5.full", 8'h00, 8'h00, 8'h00, 8'h77, 8'h00);
        chk("t5.err_pulses", 32'(err_pulses - base), 32'd0);

        // 6: readback of the duty register, or write-only behaviour
        send_frame(32'h84C3, 16);
        send_frame(32'h0400, 16);
        chk_regs("t6", 8'h00, 8'h00, 8'h00, 8'h77, 8'hC3);
`ifdef SPI_READBACK_EN
        chk("t6.cipo_bits", cipo_cap, 32'hC3);
        chk("t6.oe_mid", 32'(oe_mid), 32'h1);
`else
        chk("t6.cipo_bits", cipo_cap, 32'h00);
        chk("t6.oe_mid", 32'(oe_mid), 32'h0);
`endif
        chk("t6.oe_idle", 32'(cipo_oe), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
